// File: rtl/imem_fetch_responder_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder_if
//
// Purpose:
//   Bundles the fetch handshake, the response bus and the preload port of the
//   instruction-memory responder. The fetch stage (or the boot loader / bench)
//   uses the master modport. The responder uses the slave modport.
//
// Signals:
//   req_i        fetch request valid
//   addr_i       fetch byte address, sampled when req_i && gnt_o
//   gnt_o        request accepted this cycle (combinational)
//   flush_i      discard all outstanding requests
//   rvalid_o     one-cycle response pulse per accepted request
//   rdata_o      instruction word, zero on an error response
//   err_o        fetch error, qualified by rvalid_o
//   busy_o       at least one request outstanding (registered)
//   load_we_i    preload write enable
//   load_addr_i  preload word index
//   load_data_i  preload data
// ---------------------------------------------------------------------------
interface imem_fetch_responder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
);

  localparam int LOAD_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic                  req_i;
  logic [31:0]           addr_i;
  logic                  gnt_o;
  logic                  flush_i;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  busy_o;
  logic                  load_we_i;
  logic [LOAD_AW-1:0]    load_addr_i;
  logic [DATA_WIDTH-1:0] load_data_i;

  // Fetch stage / boot loader side
  modport master (
    output req_i, addr_i, flush_i, load_we_i, load_addr_i, load_data_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );

  // Responder side
  modport slave (
    input  req_i, addr_i, flush_i, load_we_i, load_addr_i, load_data_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );

endinterface

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
//
// Purpose:
//   Instruction-memory responder for the IF stage. It accepts fetch requests
//   through a req/gnt handshake, queues up to FIFO_DEPTH of them in order, and
//   returns one response per request after 1 + WAIT_STATES cycles of head
//   service. Misaligned and out-of-range fetches come back with err_o = 1 and a
//   zero data word. A flush drops every outstanding request without producing
//   a response. A preload port writes the backing store for the boot loader.
//
// Ports:
//   clk   single clock, all state updates on its rising edge
//   rst   synchronous active-high reset
//   bus   imem_fetch_responder_if.slave: fetch handshake, response and
//         preload signals (see the interface header for the list)
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          FIFO_DEPTH  = 2
) (
  input logic                    clk,
  input logic                    rst,
  imem_fetch_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0]    WS      = 3'(WAIT_STATES);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);

  // Window bounds are kept 33 bits wide so that a window ending exactly at
  // the top of the 4 GiB space does not wrap to zero.
  localparam logic [32:0]   BASE33  = {1'b0, BASE_ADDR};
  localparam logic [32:0]   LIMIT33 = BASE33 + (33'(DEPTH_WORDS) << 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]         q_idx [FIFO_DEPTH];
  logic                  q_err [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [2:0]            wcnt;

  logic                  gnt;
  logic                  push;
  logic                  pop;
  logic                  req_err;
  logic [AW-1:0]         req_idx;
  logic [32:0]           addr33;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  busy_q;

  // Circular pointer advance; FIFO_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Classify the incoming address and turn it into a word index. The index is
  // only meaningful when req_err is clear; error entries never read memory.
  always_comb begin
    addr33  = {1'b0, bus.addr_i};
    req_err = (bus.addr_i[1:0] != 2'b00) ||
              (addr33 < BASE33) ||
              (addr33 >= LIMIT33);
    req_idx = AW'((addr33 - BASE33) >> 2);
  end

  // Grant is withheld during reset, flush and preload writes so that the
  // queue never sees a push on an edge that is about to clear it, and so the
  // boot loader has the memory to itself while it writes.
  assign gnt  = !rst && !bus.flush_i && !bus.load_we_i && (count < FULL);
  assign push = gnt && bus.req_i;

  // The head is served once it has waited WAIT_STATES edges at the front.
  assign pop  = (count != '0) && (wcnt == WS);

  // Occupancy after this edge; a push and a pop together cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Queue payload storage. No reset is needed: only entries between rd_ptr
  // and wr_ptr are ever looked at, and push is never high during reset or
  // flush because the grant is forced low then.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= req_idx;
      q_err[wr_ptr] <= req_err;
    end
  end

  // Backing store write port. Contents survive reset. The response register
  // below reads the array with a non-blocking update on the same edge, so a
  // load and a pop hitting the same word return the old word.
  always_ff @(posedge clk) begin
    if (bus.load_we_i) begin
      mem[bus.load_addr_i] <= bus.load_data_i;
    end
  end

  // Queue control, head wait counter and registered response outputs.
  // Reset takes priority over flush; both leave the block idle with no
  // response pending and zeroed response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wcnt     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wcnt     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end

      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        wcnt     <= '0;
        rvalid_q <= 1'b1;
        err_q    <= q_err[rd_ptr];
        rdata_q  <= q_err[rd_ptr] ? '0 : mem[q_idx[rd_ptr]];
      end else begin
        rvalid_q <= 1'b0;
        if (count != '0) begin
          wcnt <= wcnt + 3'd1;
        end
      end

      count  <= count_next;
      busy_q <= (count_next != '0);
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder that serves the fetch stage's address stream and returns 32-bit instruction words.
- Accepts fetch requests through a req/gnt handshake and returns in-order responses through rvalid, with a fixed, parameterised latency.
- Queues up to FIFO_DEPTH outstanding requests, flags misaligned and out-of-range fetches, and supports flush on pipeline redirect.
- Sits between the IF stage and the on-chip instruction store; also provides a preload port for the boot loader and testbench.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- DEPTH_WORDS, 1024, number of words in the backing store.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, extra response cycles per request; legal range 0..7.
- FIFO_DEPTH, 2, maximum number of outstanding accepted requests.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  fetch request valid.
- addr_i  in  32  fetch byte address; sampled when req_i && gnt_o.
- gnt_o  out  1  request accepted this cycle (combinational).
- flush_i  in  1  discard all outstanding requests (redirect).
- rvalid_o  out  1  response valid, one-cycle pulse per request.
- rdata_o  out  DATA_WIDTH  instruction word; 0 when err_o = 1.
- err_o  out  1  fetch error; qualified by rvalid_o.
- busy_o  out  1  at least one request outstanding.
- load_we_i  in  1  preload write enable.
- load_addr_i  in  $clog2(DEPTH_WORDS)  preload word index.
- load_data_i  in  DATA_WIDTH  preload data.

Behaviour:
- Reset:
  - At an edge with rst = 1: rvalid_o, rdata_o, err_o and busy_o go to 0; queue count and wait counter clear.
  - gnt_o = 0 while rst is high.
  - Memory contents are not reset.
- Grant:
  - gnt_o = !rst && !flush_i && !load_we_i && (count < FIFO_DEPTH).
  - An accepted request pushes {addr_i, err flag} into the in-order queue.
- Error flag:
  - Set when addr_i[1:0] != 0, addr_i < BASE_ADDR, or addr_i >= BASE_ADDR + 4*DEPTH_WORDS.
  - Compute with 33-bit arithmetic, so no wrap-around occurs.
- Head sequencing (wait counter wcnt, 3 bits). Each edge with queue non-empty:
  - If wcnt == WAIT_STATES: pop the head, drive rvalid_o = 1 and rdata_o / err_o, and reset wcnt to 0.
  - Otherwise: increment wcnt and drive rvalid_o = 0.
  - With the queue empty: rvalid_o = 0.
- Latency: a request accepted at edge N gives rvalid_o high after edge N+1+WAIT_STATES.
- Throughput: with WAIT_STATES = 0, back-to-back requests are accepted every cycle and responses stream one per cycle.
- Queue occupancy: simultaneous push and pop in one edge leaves count unchanged.
- Read data:
  - Memory is read on the pop edge, at word index (addr - BASE_ADDR) >> 2.
  - Error responses drive rdata_o = 0.
- Flush:
  - At an edge with flush_i = 1, the queue empties, wcnt clears, and rvalid_o, err_o and rdata_o go to 0.
  - No response is ever produced for a flushed request. Because gnt_o = 0 during flush, no request is accepted that cycle.
- Preload:
  - On an edge with load_we_i = 1, mem[load_addr_i] <= load_data_i.
  - Same-edge load and pop to the same word returns the old data (read-before-write).
  - A load completed on an earlier edge is visible to later pops.
- busy_o is registered and equals (count != 0) after each edge.
- Simultaneous rst and flush: rst wins; the result is identical to plain reset.

Test Plan:
1. Back-to-back fetch, WAIT_STATES = 0.
   - Preload words 0..3 = 00000013, 00100093, 00200113, 00300193.
   - Issue req on 4 consecutive cycles to addr 0, 4, 8, 12.
   - Expect gnt_o high each cycle, rvalid_o high for 4 consecutive cycles starting after edge N+1, and data in order with err_o = 0.
2. Wait states and back-pressure, WAIT_STATES = 2.
   - Hold req high to addr 4, 8, 12.
   - Expect first rvalid_o after edge N+3 with data 00100093.
   - Expect gnt_o to drop while count = 2, and busy_o = 1 until the last response.
3. Error responses.
   - Request addr 0x6, then addr BASE_ADDR + 4096.
   - Expect both responses to have err_o = 1 and rdata_o = 0 at normal latency; the queue keeps order with valid fetches.
4. Flush.
   - With WAIT_STATES = 2 and two requests outstanding, assert flush_i for 1 cycle.
   - Expect no rvalid_o for the flushed requests and busy_o = 0 after the edge.
   - A following req to addr 8 returns 00200113 after edge M+3.
5. Reset mid-operation.
   - Assert rst while wcnt = 1.
   - Expect rvalid_o = 0 and busy_o = 0 after the edge, and gnt_o = 0 during rst.
   - After release, a req to addr 0 returns 00000013.
6. Preload interaction.
   - Hold load_we_i with req_i high: expect gnt_o = 0.
   - Load word 1 = DEADBEEF on the edge before a pending addr-4 pop: expect rdata_o = DEADBEEF.
   - Load on the same edge as the pop: expect the old value.
